cam_capture_unit: RTL and testbench
===================================

Name: cam_capture_unit

Overview:
- Parametrised camera capture front end. Sits between the camera parallel bus (HREF/VSYNC/8-bit data, sampled on the pixel clock) and the frame-buffer write port.
- Assembles byte pairs into pixels and converts them to RGB332 in a selectable source format. Optional 2x decimation.
- Generates clamped X/Y write addresses with a one-cycle write strobe, plus frame-level status: done pulse, frame count, line-error pulse, busy.

Parameters:
- IMG_W, 176, frame-buffer width in pixels; writes with X >= IMG_W are suppressed.
- IMG_H, 144, frame-buffer height in lines; writes with Y >= IMG_H are suppressed.
- ADDR_W, 15, width of X_ADDR and Y_ADDR.
- FCNT_W, 8, width of the frame counter.

Ports:
- CLK  in  1  camera pixel clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- HREF  in  1  line-valid from camera.
- VSYNC  in  1  frame sync from camera; high between frames.
- DATA_IN  in  8  camera data byte.
- CAPTURE_EN  in  1  arm capture; sampled only at frame start.
- FORMAT  in  2  00 RGB565, 01 RGB444 (xRGB), 10 YUV-gray, 11 treated as 00.
- DECIMATE  in  1  1 = keep even pixels of even lines only.
- W_EN  out  1  one-cycle write strobe.
- X_ADDR  out  ADDR_W  pixel column of current write.
- Y_ADDR  out  ADDR_W  pixel row of current write.
- PIXEL_OUT  out  8  RGB332 pixel.
- FRAME_DONE  out  1  one-cycle pulse at end of a captured frame.
- FRAME_CNT  out  FCNT_W  completed-frame count; wraps.
- LINE_ERR  out  1  one-cycle pulse when a line ends on an odd byte.
- BUSY  out  1  high while in ACTIVE.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte phase 0; internal counters 0; HREF_d/VSYNC_d 0.
- Edge detection uses registered HREF_d/VSYNC_d. No logic is clocked by HREF or VSYNC.
- FSM:
  - IDLE -> SYNC on a VSYNC rising edge while CAPTURE_EN = 1.
  - SYNC (VSYNC high) -> ACTIVE on a VSYNC falling edge. On entry: raw line counter = 0, raw pixel counter = 0, phase = 0. FORMAT and DECIMATE are latched at this edge and held for the whole frame.
  - ACTIVE -> IDLE on a VSYNC rising edge. FRAME_DONE pulses and FRAME_CNT increments in the same cycle. If CAPTURE_EN = 1 at that edge, go directly to SYNC instead of IDLE; FRAME_DONE still pulses.
  - A partial frame after reset is always discarded, because only a VSYNC rise arms the FSM.
- Byte assembly (ACTIVE, HREF = 1):
  - phase 0: store DATA_IN as b1, then phase = 1.
  - phase 1: combine with DATA_IN as b2, then phase = 0 and raw pixel counter +1.
- Conversion, using latched FORMAT:
  - RGB565: {b1[7:5], b1[2:0], b2[4:3]}.
  - RGB444: {b1[3:1], b2[7:5], b2[3:2]}.
  - YUV-gray: {b1[7:5], b1[7:5], b1[7:6]}, where b1 is the Y byte.
- Write (phase-1 cycle), registered with latency 1:
  - The cycle after the second byte is sampled: W_EN = 1, PIXEL_OUT, X_ADDR and Y_ADDR valid together.
  - First pixel of each line is written at X_ADDR = 0.
- Addressing:
  - DECIMATE = 0: X = raw pixel, Y = raw line.
  - DECIMATE = 1: a write occurs only if raw pixel[0] = 0 and raw line[0] = 0; then X = raw pixel >> 1, Y = raw line >> 1.
  - W_EN is suppressed when X >= IMG_W or Y >= IMG_H. Counters keep counting and are clamped at their all-ones value; no wrap within a frame.
- HREF falling edge (ACTIVE): raw line +1, raw pixel = 0. If phase = 1, LINE_ERR pulses and the half pixel is dropped. Phase returns to 0.
- HREF high while VSYNC high is ignored.
- X_ADDR, Y_ADDR and PIXEL_OUT hold their last values when W_EN = 0.
- Simultaneous events: a VSYNC rise takes priority over an HREF fall in the same cycle. No line increment and no LINE_ERR occur.
- CAPTURE_EN dropping mid-frame has no effect until the next frame boundary.
- RESET asserted mid-frame: immediate return to reset values; a clean VSYNC rise is required before capture resumes.

Test Plan:
- RGB565 capture: CAPTURE_EN = 1, VSYNC pulse, one line of 4 pixels with byte pairs (E0,00),(07,00),(00,18),(FF,FF) -> W_EN on cycles 3, 5, 7, 9 after HREF rise; PIXEL_OUT E0, 1C, 03, FF; X_ADDR 0..3, Y_ADDR 0.
- Frame timing: 3 lines of 2 pixels, then VSYNC rise -> 6 writes at Y 0..2; FRAME_DONE single pulse on the VSYNC-rise cycle; FRAME_CNT 0 -> 1; BUSY falls the same cycle.
- Decimation and clamp: DECIMATE = 1, IMG_W = 4, 10 pixels x 4 lines -> writes only on lines 0 and 2 at Y 0 and 1; X 0..3 only, i.e. 4 writes per kept line.
- Odd line: HREF high for 5 bytes -> 2 writes and a LINE_ERR pulse at the HREF fall; next line starts at X 0, phase 0 (first write correct).
- Format switch: FORMAT changed to RGB444 mid-frame -> conversion unchanged until the next VSYNC fall. Then bytes (0F,F0) -> PIXEL_OUT FC.
- Reset mid-line: assert RESET during HREF -> all outputs 0 immediately. Subsequent HREF activity without a VSYNC rise -> no W_EN. After a VSYNC pulse -> capture resumes at X 0, Y 0.

Source files
------------

// File: rtl/cam_capture_unit.sv
// Camera capture front end: pairs bytes from the parallel camera bus into pixels,
// converts them to RGB332 and emits clamped X/Y frame-buffer writes.
// Latency: write strobe, pixel and address appear one cycle after the second byte is sampled.
// Backpressure: none; the camera cannot be stalled, so every byte is consumed as it arrives.
//
// Ports:
//   CLK, RESET            pixel clock, asynchronous active-high reset
//   HREF, VSYNC, DATA_IN  camera line-valid, frame sync (high between frames), data byte
//   CAPTURE_EN            arms capture, only looked at on a frame boundary
//   FORMAT, DECIMATE      source format / 2x decimation, latched when a frame starts
//   W_EN, X_ADDR, Y_ADDR, PIXEL_OUT   frame-buffer write port (addr/data hold between writes)
//   FRAME_DONE, FRAME_CNT, LINE_ERR, BUSY   frame status
module cam_capture_unit #(
  parameter int IMG_W  = 176,
  parameter int IMG_H  = 144,
  parameter int ADDR_W = 15,
  parameter int FCNT_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              HREF,
  input  logic              VSYNC,
  input  logic [7:0]        DATA_IN,
  input  logic              CAPTURE_EN,
  input  logic [1:0]        FORMAT,
  input  logic              DECIMATE,
  output logic              W_EN,
  output logic [ADDR_W-1:0] X_ADDR,
  output logic [ADDR_W-1:0] Y_ADDR,
  output logic [7:0]        PIXEL_OUT,
  output logic              FRAME_DONE,
  output logic [FCNT_W-1:0] FRAME_CNT,
  output logic              LINE_ERR,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [1:0] FMT_RGB444 = 2'b01;
  localparam logic [1:0] FMT_YUV    = 2'b10;

  // One extra bit so that limits equal to 2**ADDR_W still compare correctly.
  localparam logic [ADDR_W:0] X_LIM = (ADDR_W+1)'(IMG_W);
  localparam logic [ADDR_W:0] Y_LIM = (ADDR_W+1)'(IMG_H);

  state_t              state_q;
  logic                href_dly_q;
  logic                vsync_dly_q;
  logic                phase_q;
  logic [7:0]          b1_q;
  logic [ADDR_W-1:0]   pix_q;
  logic [ADDR_W-1:0]   line_q;
  logic [1:0]          fmt_q;
  logic                dec_q;
  logic                w_en_q;
  logic [ADDR_W-1:0]   x_addr_q;
  logic [ADDR_W-1:0]   y_addr_q;
  logic [7:0]          pixel_q;
  logic                frame_done_q;
  logic [FCNT_W-1:0]   fcnt_q;
  logic                line_err_q;
  logic                busy_q;

  logic                href_fall;
  logic                vsync_rise;
  logic                vsync_fall;
  logic [7:0]          pixel_d;
  logic [ADDR_W-1:0]   x_d;
  logic [ADDR_W-1:0]   y_d;
  logic                wr_ok_d;
  logic [ADDR_W-1:0]   pix_inc_d;
  logic [ADDR_W-1:0]   line_inc_d;

  assign href_fall  = href_dly_q & ~HREF;
  assign vsync_rise = VSYNC & ~vsync_dly_q;
  assign vsync_fall = ~VSYNC & vsync_dly_q;

  // Pixel formed from the stored first byte and the byte on the bus right now.
  always_comb begin
    pixel_d = {b1_q[7:5], b1_q[2:0], DATA_IN[4:3]};
    case (fmt_q)
      FMT_RGB444: pixel_d = {b1_q[3:1], DATA_IN[7:5], DATA_IN[3:2]};
      FMT_YUV:    pixel_d = {b1_q[7:5], b1_q[7:5], b1_q[7:6]};
      default:    pixel_d = {b1_q[7:5], b1_q[2:0], DATA_IN[4:3]};
    endcase
  end

  // Address mapping, decimation keep test and frame-buffer bounds check.
  always_comb begin
    x_d     = pix_q;
    y_d     = line_q;
    wr_ok_d = 1'b1;
    if (dec_q) begin
      x_d     = pix_q >> 1;
      y_d     = line_q >> 1;
      wr_ok_d = ~pix_q[0] & ~line_q[0];
    end
    if (({1'b0, x_d} >= X_LIM) || ({1'b0, y_d} >= Y_LIM)) begin
      wr_ok_d = 1'b0;
    end
  end

  // Raw counters saturate so an oversize frame cannot wrap back onto row/column 0.
  always_comb begin
    pix_inc_d  = (&pix_q)  ? pix_q  : pix_q + 1'b1;
    line_inc_d = (&line_q) ? line_q : line_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      href_dly_q   <= 1'b0;
      vsync_dly_q  <= 1'b0;
      phase_q      <= 1'b0;
      b1_q         <= 8'h00;
      pix_q        <= '0;
      line_q       <= '0;
      fmt_q        <= 2'b00;
      dec_q        <= 1'b0;
      w_en_q       <= 1'b0;
      x_addr_q     <= '0;
      y_addr_q     <= '0;
      pixel_q      <= 8'h00;
      frame_done_q <= 1'b0;
      fcnt_q       <= '0;
      line_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      href_dly_q   <= HREF;
      vsync_dly_q  <= VSYNC;
      w_en_q       <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (vsync_rise && CAPTURE_EN) begin
            state_q <= ST_SYNC;
          end
        end

        ST_SYNC: begin
          // HREF during the vertical blank is ignored; the frame starts on VSYNC fall.
          if (vsync_fall) begin
            state_q <= ST_ACTIVE;
            busy_q  <= 1'b1;
            line_q  <= '0;
            pix_q   <= '0;
            phase_q <= 1'b0;
            fmt_q   <= FORMAT;
            dec_q   <= DECIMATE;
          end
        end

        ST_ACTIVE: begin
          // End of frame wins over a coincident HREF fall: no line step, no line error.
          if (vsync_rise) begin
            frame_done_q <= 1'b1;
            fcnt_q       <= fcnt_q + 1'b1;
            busy_q       <= 1'b0;
            phase_q      <= 1'b0;
            state_q      <= CAPTURE_EN ? ST_SYNC : ST_IDLE;
          end else if (href_fall) begin
            line_q  <= line_inc_d;
            pix_q   <= '0;
            phase_q <= 1'b0;
            // A dangling first byte means the line had an odd byte count.
            if (phase_q) begin
              line_err_q <= 1'b1;
            end
          end else if (HREF && !VSYNC) begin
            if (!phase_q) begin
              b1_q    <= DATA_IN;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              pix_q   <= pix_inc_d;
              if (wr_ok_d) begin
                w_en_q   <= 1'b1;
                x_addr_q <= x_d;
                y_addr_q <= y_d;
                pixel_q  <= pixel_d;
              end
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign W_EN       = w_en_q;
  assign X_ADDR     = x_addr_q;
  assign Y_ADDR     = y_addr_q;
  assign PIXEL_OUT  = pixel_q;
  assign FRAME_DONE = frame_done_q;
  assign FRAME_CNT  = fcnt_q;
  assign LINE_ERR   = line_err_q;
  assign BUSY       = busy_q;

  // Byte bits that no supported format maps into RGB332.
  logic unused_bits;
  assign unused_bits = ^{DATA_IN[1:0], b1_q[4]};

endmodule

// File: tb/tb_cam_capture_unit.sv
// Directed bench for cam_capture_unit, built with a 4x3 frame buffer so the
// X and Y clamps are reachable with short frames.
module tb_cam_capture_unit;

  localparam int AW = 15;
  localparam int FW = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          HREF;
  logic          VSYNC;
  logic [7:0]    DATA_IN;
  logic          CAPTURE_EN;
  logic [1:0]    FORMAT;
  logic          DECIMATE;
  logic          W_EN;
  logic [AW-1:0] X_ADDR;
  logic [AW-1:0] Y_ADDR;
  logic [7:0]    PIXEL_OUT;
  logic          FRAME_DONE;
  logic [FW-1:0] FRAME_CNT;
  logic          LINE_ERR;
  logic          BUSY;

  cam_capture_unit #(.IMG_W(4), .IMG_H(3), .ADDR_W(AW), .FCNT_W(FW)) dut (
    .CLK(CLK), .RESET(RESET), .HREF(HREF), .VSYNC(VSYNC), .DATA_IN(DATA_IN),
    .CAPTURE_EN(CAPTURE_EN), .FORMAT(FORMAT), .DECIMATE(DECIMATE),
    .W_EN(W_EN), .X_ADDR(X_ADDR), .Y_ADDR(Y_ADDR), .PIXEL_OUT(PIXEL_OUT),
    .FRAME_DONE(FRAME_DONE), .FRAME_CNT(FRAME_CNT), .LINE_ERR(LINE_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic [7:0]    p;
  } wr_t;

  wr_t           wq[$];
  logic [7:0]    tx_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [FW-1:0] exp_fcnt = '0;

  // Write log, sampled mid-cycle.
  always @(negedge CLK) begin
    if (W_EN === 1'b1) wq.push_back({X_ADDR, Y_ADDR, PIXEL_OUT});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives tx_q as one HREF line, then returns right after the HREF-fall edge.
  task automatic send_line();
    HREF = 1'b1;
    for (int i = 0; i < tx_q.size(); i++) begin
      DATA_IN = tx_q[i];
      tick();
    end
    HREF    = 1'b0;
    DATA_IN = 8'h00;
    tick();
    tx_q.delete();
  endtask

  task automatic frame_start();
    if (VSYNC !== 1'b1) begin
      VSYNC = 1'b1;
      tick();
      tick();
    end
    VSYNC = 1'b0;
    tick();
    tick();
  endtask

  task automatic close_frame();
    VSYNC = 1'b1;
    tick();
    exp_fcnt = exp_fcnt + 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1; HREF = 1'b0; VSYNC = 1'b0; DATA_IN = 8'h00;
    CAPTURE_EN = 1'b0; FORMAT = 2'b00; DECIMATE = 1'b0;
    tick();
    vectors++;
    if ({W_EN, FRAME_DONE, LINE_ERR, BUSY} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b required 0000", {W_EN, FRAME_DONE, LINE_ERR, BUSY});
    end
    vectors++;
    if ({X_ADDR, Y_ADDR, PIXEL_OUT, FRAME_CNT} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got x=%0d y=%0d p=%h cnt=%0d required all 0",
               X_ADDR, Y_ADDR, PIXEL_OUT, FRAME_CNT);
    end
    RESET = 1'b0;
    tick();
    // Idle and not armed: line traffic must not write.
    wq.delete();
    tx_q = '{8'hE0, 8'h00, 8'h07, 8'h00};
    send_line();
    vectors++;
    if (wq.size() !== 0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_write: got writes=%0d busy=%b required 0 0", wq.size(), BUSY);
    end
  endtask

  task automatic test_rgb565();
    logic [7:0] b1s[4] = '{8'hE0, 8'h07, 8'h00, 8'hFF};
    logic [7:0] b2s[4] = '{8'h00, 8'h00, 8'h18, 8'hFF};
    logic [7:0] exp[4] = '{8'hE0, 8'h1C, 8'h03, 8'hFF};
    CAPTURE_EN = 1'b1; FORMAT = 2'b00; DECIMATE = 1'b0;
    frame_start();
    vectors++;
    if (BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_active: got %b required 1", BUSY);
    end
    HREF = 1'b1;
    for (int i = 0; i < 4; i++) begin
      DATA_IN = b1s[i];
      tick();
      vectors++;
      if (W_EN !== 1'b0 || (i > 0 && X_ADDR !== AW'(i - 1))) begin
        miscompares++;
        $display("FAIL rgb565_gap%0d: got w_en=%b x=%0d required 0 (x held)", i, W_EN, X_ADDR);
      end
      DATA_IN = b2s[i];
      tick();
      vectors++;
      if ({W_EN, X_ADDR, Y_ADDR, PIXEL_OUT} !== {1'b1, AW'(i), AW'(0), exp[i]}) begin
        miscompares++;
        $display("FAIL rgb565_px%0d: got w=%b x=%0d y=%0d p=%h required 1 %0d 0 %h",
                 i, W_EN, X_ADDR, Y_ADDR, PIXEL_OUT, i, exp[i]);
      end
    end
    HREF = 1'b0;
    tick();
    VSYNC = 1'b1;
    tick();
    exp_fcnt = exp_fcnt + 1'b1;
    vectors++;
    if ({FRAME_DONE, BUSY, FRAME_CNT} !== {1'b1, 1'b0, exp_fcnt}) begin
      miscompares++;
      $display("FAIL rgb565_done: got done=%b busy=%b cnt=%0d required 1 0 %0d",
               FRAME_DONE, BUSY, FRAME_CNT, exp_fcnt);
    end
    tick();
    vectors++;
    if (FRAME_DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse_width: got %b required 0", FRAME_DONE);
    end
  endtask

  task automatic test_frame_timing();
    frame_start();
    wq.delete();
    for (int l = 0; l < 3; l++) begin
      tx_q = '{8'hE0, 8'h00, 8'h07, 8'h00};
      send_line();
    end
    vectors++;
    if (wq.size() !== 6) begin
      miscompares++;
      $display("FAIL frame_write_count: got %0d required 6", wq.size());
    end
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      vectors++;
      if (wq[i] !== {AW'(i % 2), AW'(i / 2), ((i % 2) != 0) ? 8'h1C : 8'hE0}) begin
        miscompares++;
        $display("FAIL frame_write%0d: got x=%0d y=%0d p=%h required x=%0d y=%0d",
                 i, wq[i].x, wq[i].y, wq[i].p, i % 2, i / 2);
      end
    end
    vectors++;
    if (FRAME_DONE !== 1'b0 || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_done: got done=%b busy=%b required 0 1", FRAME_DONE, BUSY);
    end
    VSYNC = 1'b1;
    tick();
    exp_fcnt = exp_fcnt + 1'b1;
    vectors++;
    if ({FRAME_DONE, BUSY, FRAME_CNT} !== {1'b1, 1'b0, exp_fcnt}) begin
      miscompares++;
      $display("FAIL frame_done: got done=%b busy=%b cnt=%0d required 1 0 %0d",
               FRAME_DONE, BUSY, FRAME_CNT, exp_fcnt);
    end
    tick();
    // Re-armed in the blank: HREF while VSYNC is high must be ignored.
    wq.delete();
    tx_q = '{8'hFF, 8'hFF};
    send_line();
    vectors++;
    if (wq.size() !== 0) begin
      miscompares++;
      $display("FAIL href_in_blank: got %0d writes required 0", wq.size());
    end
    frame_start();
    tx_q = '{8'h07, 8'h00};
    send_line();
    vectors++;
    if (wq.size() !== 1 || wq[0] !== {AW'(0), AW'(0), 8'h1C}) begin
      miscompares++;
      $display("FAIL back_to_back_first: got n=%0d required one write at 0,0 p=1c", wq.size());
    end
    close_frame();
  endtask

  task automatic test_clamp_y();
    frame_start();
    wq.delete();
    for (int l = 0; l < 4; l++) begin
      tx_q = '{8'hFF, 8'hFF};
      send_line();
    end
    vectors++;
    if (wq.size() !== 3 || wq[wq.size() - 1].y !== AW'(2)) begin
      miscompares++;
      $display("FAIL clamp_y: got n=%0d required 3 writes, last y=2", wq.size());
    end
    close_frame();
  endtask

  task automatic test_decimate();
    logic [7:0] b1;
    DECIMATE = 1'b1;
    frame_start();
    DECIMATE = 1'b0;  // must stay latched for the whole frame
    wq.delete();
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < 10; k++) begin
        b1 = {3'(k), 5'b00000};
        tx_q.push_back(b1);
        tx_q.push_back(8'h00);
      end
      send_line();
    end
    vectors++;
    if (wq.size() !== 8) begin
      miscompares++;
      $display("FAIL decimate_count: got %0d required 8", wq.size());
    end
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      vectors++;
      if (wq[i] !== {AW'(i % 4), AW'(i / 4), {3'(2 * (i % 4)), 5'b00000}}) begin
        miscompares++;
        $display("FAIL decimate_write%0d: got x=%0d y=%0d p=%h required x=%0d y=%0d",
                 i, wq[i].x, wq[i].y, wq[i].p, i % 4, i / 4);
      end
    end
    close_frame();
  endtask

  task automatic test_odd_line();
    frame_start();
    wq.delete();
    tx_q = '{8'hE0, 8'h00, 8'h07, 8'h00, 8'hE0};
    send_line();
    vectors++;
    if (LINE_ERR !== 1'b1) begin
      miscompares++;
      $display("FAIL line_err_pulse: got %b required 1", LINE_ERR);
    end
    tick();
    vectors++;
    if (LINE_ERR !== 1'b0 || wq.size() !== 2) begin
      miscompares++;
      $display("FAIL odd_line_after: got err=%b writes=%0d required 0 2", LINE_ERR, wq.size());
    end
    wq.delete();
    tx_q = '{8'h00, 8'h18};
    send_line();
    vectors++;
    if (wq.size() !== 1 || wq[0] !== {AW'(0), AW'(1), 8'h03} || LINE_ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL odd_line_recover: got n=%0d err=%b required one write x=0 y=1 p=03",
               wq.size(), LINE_ERR);
    end
    // VSYNC rise together with an HREF fall on an odd byte: frame ends, no line error.
    HREF = 1'b1;
    DATA_IN = 8'hE0; tick();
    DATA_IN = 8'h00; tick();
    DATA_IN = 8'hFF; tick();
    HREF = 1'b0;
    VSYNC = 1'b1;
    tick();
    exp_fcnt = exp_fcnt + 1'b1;
    vectors++;
    if ({FRAME_DONE, LINE_ERR, FRAME_CNT} !== {1'b1, 1'b0, exp_fcnt}) begin
      miscompares++;
      $display("FAIL vsync_over_href: got done=%b err=%b cnt=%0d required 1 0 %0d",
               FRAME_DONE, LINE_ERR, FRAME_CNT, exp_fcnt);
    end
    tick();
  endtask

  task automatic test_format_switch();
    logic [1:0] fmts[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [7:0] b1s[4]  = '{8'h0F, 8'h0F, 8'hA5, 8'h0F};
    logic [7:0] b2s[4]  = '{8'hF0, 8'hF0, 8'h00, 8'hF0};
    logic [7:0] exp[4]  = '{8'h1E, 8'hFC, 8'hB6, 8'h1E};
    for (int f = 0; f < 4; f++) begin
      FORMAT = fmts[f];
      frame_start();
      FORMAT = 2'b01;  // mid-frame change has no effect
      wq.delete();
      tx_q = '{b1s[f], b2s[f]};
      send_line();
      vectors++;
      if (wq.size() !== 1 || wq[0].p !== exp[f]) begin
        miscompares++;
        $display("FAIL format_%0d: got n=%0d p=%h required 1 %h",
                 f, wq.size(), (wq.size() > 0) ? wq[0].p : 8'hxx, exp[f]);
      end
      close_frame();
    end
    FORMAT = 2'b00;
  endtask

  task automatic test_capture_en();
    frame_start();
    CAPTURE_EN = 1'b0;
    wq.delete();
    tx_q = '{8'hE0, 8'h00};
    send_line();
    vectors++;
    if (wq.size() !== 1) begin
      miscompares++;
      $display("FAIL en_drop_midframe: got %0d writes required 1", wq.size());
    end
    VSYNC = 1'b1;
    tick();
    exp_fcnt = exp_fcnt + 1'b1;
    vectors++;
    if ({FRAME_DONE, BUSY, FRAME_CNT} !== {1'b1, 1'b0, exp_fcnt}) begin
      miscompares++;
      $display("FAIL en_drop_done: got done=%b busy=%b cnt=%0d required 1 0 %0d",
               FRAME_DONE, BUSY, FRAME_CNT, exp_fcnt);
    end
    tick();
    // Arming while VSYNC is already high is not a rising edge.
    CAPTURE_EN = 1'b1;
    tick();
    VSYNC = 1'b0;
    tick();
    tick();
    wq.delete();
    tx_q = '{8'hE0, 8'h00};
    send_line();
    vectors++;
    if (wq.size() !== 0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL no_rise_no_arm: got writes=%0d busy=%b required 0 0", wq.size(), BUSY);
    end
  endtask

  task automatic test_reset_mid_line();
    frame_start();
    HREF = 1'b1;
    DATA_IN = 8'hE0; tick();
    DATA_IN = 8'h00; tick();
    DATA_IN = 8'h07; tick();
    #2;
    RESET = 1'b1;
    #1;
    exp_fcnt = '0;
    vectors++;
    if ({W_EN, X_ADDR, Y_ADDR, PIXEL_OUT, FRAME_DONE, FRAME_CNT, LINE_ERR, BUSY} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got w=%b p=%h cnt=%0d busy=%b required all 0",
               W_EN, PIXEL_OUT, FRAME_CNT, BUSY);
    end
    tick();
    RESET = 1'b0;
    wq.delete();
    for (int i = 0; i < 4; i++) begin
      DATA_IN = 8'hFF;
      tick();
    end
    HREF = 1'b0;
    tick();
    tx_q = '{8'hFF, 8'hFF};
    send_line();
    vectors++;
    if (wq.size() !== 0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_disarmed: got writes=%0d busy=%b required 0 0", wq.size(), BUSY);
    end
    frame_start();
    tx_q = '{8'hE0, 8'h00};
    send_line();
    vectors++;
    if (wq.size() !== 1 || wq[0] !== {AW'(0), AW'(0), 8'hE0}) begin
      miscompares++;
      $display("FAIL reset_resume: got n=%0d required one write x=0 y=0 p=e0", wq.size());
    end
    close_frame();
    vectors++;
    if (FRAME_CNT !== exp_fcnt) begin
      miscompares++;
      $display("FAIL reset_fcnt: got %0d required %0d", FRAME_CNT, exp_fcnt);
    end
  endtask

  initial begin
    test_reset();
    test_rgb565();
    test_frame_timing();
    test_clamp_y();
    test_decimate();
    test_odd_line();
    test_format_switch();
    test_capture_en();
    test_reset_mid_line();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
